// File: rtl/axis_capture_pkg.sv
// Shared types and constants for the AXI-Stream capture sink.
// Optional statistics outputs are enabled by defining AXIS_CAPTURE_STATS_EN.
package axis_capture_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    // Extremes of the default sample width, used to seed the running min/max.
    localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/axis_capture_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module axis_capture_ram #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register holds the last popped word between pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_capture_sink.sv
// AXI-Stream capture sink: armed capture of a fixed-length sample run, optional
// level trigger, drained through a pop port. Stats via AXIS_CAPTURE_STATS_EN.
module axis_capture_sink
    import axis_capture_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic signed [DATA_W-1:0] s_axis_tdata,
    input  logic                     arm,
    input  logic        [ADDR_W:0]   cap_len,
    input  logic                     trig_en,
    input  logic signed [DATA_W-1:0] trig_level,
    input  logic                     rd_en,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic        [ADDR_W:0]   fill_count
`ifdef AXIS_CAPTURE_STATS_EN
    ,
    output logic signed [DATA_W-1:0] min_val,
    output logic signed [DATA_W-1:0] max_val
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    cap_state_e              state_q, state_d;
    logic        [ADDR_W:0]  len_q, len_d;
    logic        [ADDR_W:0]  fill_q, fill_d;
    logic      [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic      [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic                    trig_en_q, trig_en_d;
    logic signed [DATA_W-1:0] level_q, level_d;
    logic signed [DATA_W-1:0] prev_q, prev_d;
    logic                    prev_valid_q, prev_valid_d;
    logic                    tready_q, tready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    accept_c, store_c, pop_c, fire_c;
`ifdef AXIS_CAPTURE_STATS_EN
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic signed [DATA_W-1:0] min_q, min_d;
    logic signed [DATA_W-1:0] max_q, max_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            trig_en_q    <= 1'b0;
            level_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
`ifdef AXIS_CAPTURE_STATS_EN
            min_q        <= '0;
            max_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trig_en_q    <= trig_en_d;
            level_q      <= level_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            tready_q     <= tready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_valid_q   <= rd_valid_d;
`ifdef AXIS_CAPTURE_STATS_EN
            min_q        <= min_d;
            max_q        <= max_d;
`endif
        end
    end

    assign accept_c = s_axis_tvalid & tready_q;
    assign fire_c   = prev_valid_q && (prev_q < level_q) && (s_axis_tdata >= level_q);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        fill_d       = fill_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        trig_en_d    = trig_en_q;
        level_d      = level_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        store_c      = 1'b0;
        pop_c        = 1'b0;
`ifdef AXIS_CAPTURE_STATS_EN
        min_d        = min_q;
        max_d        = max_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new arm discards any unread data and wins over a pop.
                if (arm) begin
                    state_d      = ST_ARMED;
                    fill_d       = '0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    prev_valid_d = 1'b0;
                    trig_en_d    = trig_en;
                    level_d      = trig_level;
                    len_d        = ((cap_len == '0) || (cap_len > DEPTH_L)) ? DEPTH_L : cap_len;
`ifdef AXIS_CAPTURE_STATS_EN
                    min_d        = S_MAX;
                    max_d        = S_MIN;
`endif
                end else if ((state_q == ST_DONE) && rd_en && (fill_q != '0)) begin
                    pop_c    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    fill_d   = fill_q - ONE_L;
                end
            end
            ST_ARMED: begin
                if (accept_c) begin
                    if (!trig_en_q || fire_c) begin
                        store_c = 1'b1;
                    end else begin
                        prev_d       = s_axis_tdata;
                        prev_valid_d = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                store_c = accept_c;
            end
            default: state_d = ST_IDLE;
        endcase

        if (store_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_q + ONE_L;
            if ((fill_q + ONE_L) == len_q) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_CAPTURE;
            end
`ifdef AXIS_CAPTURE_STATS_EN
            if (s_axis_tdata < min_q) min_d = s_axis_tdata;
            if (s_axis_tdata > max_q) max_d = s_axis_tdata;
`endif
        end

        tready_d   = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        busy_d     = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d     = (state_d == ST_DONE);
        rd_valid_d = pop_c;
    end

    axis_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (store_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_axis_tdata),
        .re_i    (pop_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign s_axis_tready = tready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign rd_valid      = rd_valid_q;
    assign fill_count    = fill_q;
`ifdef AXIS_CAPTURE_STATS_EN
    assign min_val       = min_q;
    assign max_val       = max_q;
`endif

endmodule
